imem_boot_loader: RTL and testbench

//  Upstream loader for the multi-cycle core's 32x32 instruction memory. Accepts a byte stream
//  (length, payload, XOR checksum) over a valid/ready link and packs it into 32-bit words.

---
 rtl/imem_boot_loader_pkg.sv | 17 +
 rtl/imem_boot_loader_word_assembler.sv | 44 ++++
 rtl/imem_boot_loader.sv | 124 ++++++++++++
 tb/tb_imem_boot_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_e   : loader FSM states (length, payload, checksum, done, error)
//   ByteWidth : width of one stream byte
`timescale 1ns/1ps
package imem_boot_loader_pkg;

  localparam int unsigned ByteWidth = 8;

  typedef enum logic [2:0] {
    StLen,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Shift-in byte packer: collects DATA_WIDTH/8 bytes, first byte ends up most significant.
//   clk, reset  : clock, synchronous active-low reset
//   clear       : drop any partial word and restart the byte count
//   load        : byte_in is consumed this cycle
//   byte_in     : stream byte
//   word        : word as it will look once byte_in is shifted in (valid with word_valid)
//   word_valid  : load of the final byte of a word this cycle
`timescale 1ns/1ps
module imem_boot_loader_word_assembler
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [ByteWidth-1:0]  byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_valid
);

  localparam int unsigned Bytes = DATA_WIDTH / ByteWidth;
  localparam int unsigned CntW  = (Bytes > 1) ? $clog2(Bytes) : 1;

  logic [DATA_WIDTH-1:0] pack_q;
  logic [CntW-1:0]       cnt_q;
  logic                  last;

  assign last       = (cnt_q == CntW'(Bytes - 1));
  assign word       = (pack_q << ByteWidth) | DATA_WIDTH'(byte_in);
  assign word_valid = load & last;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      pack_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      pack_q <= word;
      cnt_q  <= last ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives length, payload and XOR checksum bytes over valid/ready, packs the
// payload into words, writes them to instruction memory and releases the core once the
// checksum verifies.
//   clk, reset     : clock, synchronous active-low reset
//   in_valid/in_data/in_ready : byte stream input (transfer = in_valid & in_ready)
//   imem_we/imem_addr/imem_wdata : one-cycle instruction-memory write port
//   core_run       : image loaded and verified (held until reset)
//   load_error     : bad length or checksum (held until reset)
//   words_loaded   : number of words written since reset
`timescale 1ns/1ps
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_run,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned Words = 2 ** ADDR_WIDTH;

  state_e                state_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   words_q;
  logic [7:0]            csum_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  run_q;
  logic                  err_q;

  logic                  xfer;
  logic [31:0]           n_req;
  logic [ADDR_WIDTH:0]   words_next;
  logic [DATA_WIDTH-1:0] asm_word;
  logic                  asm_valid;

  // Ready is suppressed combinationally during the reset cycle itself.
  assign in_ready   = reset & (state_q inside {StLen, StData, StCsum});
  assign xfer       = in_valid & in_ready;
  // A length byte of zero stands for a full memory image.
  assign n_req      = (in_data == 8'd0) ? 32'(Words) : {24'd0, in_data};
  assign words_next = words_q + 1'b1;

  imem_boot_loader_word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (xfer && (state_q == StLen)),
    .load       (xfer && (state_q == StData)),
    .byte_in    (in_data),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StLen;
      len_q   <= '0;
      words_q <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (xfer) begin
        unique case (state_q)
          StLen: begin
            if (n_req > Words) begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end else begin
              len_q   <= n_req[ADDR_WIDTH:0];
              csum_q  <= '0;
              state_q <= StData;
            end
          end
          StData: begin
            csum_q <= csum_q ^ in_data;
            if (asm_valid) begin
              we_q    <= 1'b1;
              addr_q  <= words_q[ADDR_WIDTH-1:0];
              wdata_q <= asm_word;
              words_q <= words_next;
              if (words_next == len_q) state_q <= StCsum;
            end
          end
          StCsum: begin
            if (in_data == csum_q) begin
              state_q <= StDone;
              run_q   <= 1'b1;
            end else begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign core_run     = run_q;
  assign load_error   = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
`timescale 1ns/1ps
module tb_imem_boot_loader;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int WORDS = 32;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          core_run;
  logic          load_error;
  logic [AW:0]   words_loaded;

  imem_boot_loader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_run     (core_run),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  bit   gaps   = 0;
  logic prev_we = 1'b0;
  wr_t  mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", imem_addr,
                 imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("imem_addr", 64'(imem_addr), 64'(mon_e.addr));
        check("imem_wdata", 64'(imem_wdata), 64'(mon_e.data));
      end
      check("imem_we_single_cycle", 64'(prev_we), 64'(0));
    end
    check("run_err_exclusive", 64'(core_run & load_error), 64'(0));
    prev_we = imem_we;
  end

  task automatic send_byte(input logic [7:0] b);
    int  guard = 0;
    bit  done  = 0;
    while (!done) begin
      @(negedge clk);
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        if (in_ready) begin
          @(posedge clk);
          #1 in_valid = 1'b0;
          done = 1;
        end else begin
          guard++;
          if (guard > 20) begin
            check("in_ready_timeout", 64'(in_ready), 64'(1));
            in_valid = 1'b0;
            done = 1;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1 check("in_ready_during_reset", 64'(in_ready), 64'(0));
    @(posedge clk);
    @(negedge clk);
    check("rst_imem_we", 64'(imem_we), 64'(0));
    check("rst_imem_addr", 64'(imem_addr), 64'(0));
    check("rst_imem_wdata", 64'(imem_wdata), 64'(0));
    check("rst_core_run", 64'(core_run), 64'(0));
    check("rst_load_error", 64'(load_error), 64'(0));
    check("rst_words_loaded", 64'(words_loaded), 64'(0));
    reset = 1'b1;
  endtask

  // Reference model: length byte 0 means a full memory, payload is packed big-endian into
  // consecutive words from address 0, checksum is the XOR of all payload bytes.
  task automatic run_image(input logic [7:0] len_b, input bq_t pl, input bit bad,
                           input int abort_after);
    int         n;
    int         nwords;
    int         nbytes;
    logic [7:0] cs;
    wr_t        w;
    n = (len_b == 8'd0) ? WORDS : int'(len_b);
    if (n > WORDS) begin
      send_byte(len_b);
      @(negedge clk);
      check("len_err_flag", 64'(load_error), 64'(1));
      check("len_err_run", 64'(core_run), 64'(0));
      check("len_err_words", 64'(words_loaded), 64'(0));
      check("len_err_ready", 64'(in_ready), 64'(0));
      return;
    end
    cs = 8'd0;
    for (int i = 0; i < 4 * n; i++) cs = cs ^ pl[i];
    nbytes = (abort_after >= 0) ? abort_after : 4 * n;
    nwords = nbytes / 4;
    for (int k = 0; k < nwords; k++) begin
      w.addr = AW'(k);
      w.data = {pl[4*k], pl[4*k+1], pl[4*k+2], pl[4*k+3]};
      exp_q.push_back(w);
    end
    send_byte(len_b);
    for (int i = 0; i < nbytes; i++) send_byte(pl[i]);
    if (abort_after >= 0) begin
      do_reset();
      check("abort_writes_drained", 64'(exp_q.size()), 64'(0));
      return;
    end
    send_byte(bad ? (cs ^ 8'($urandom_range(1, 255))) : cs);
    @(negedge clk);
    check("core_run", 64'(core_run), 64'(!bad));
    check("load_error", 64'(load_error), 64'(bad));
    repeat (2) @(negedge clk);
    check("words_loaded", 64'(words_loaded), 64'(n));
    check("writes_drained", 64'(exp_q.size()), 64'(0));
    check("ready_after_end", 64'(in_ready), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t t1;
    bq_t pl;
    int  n;
    t1 = '{8'h05, 8'h00, 8'h00, 8'h13, 8'h00, 8'hA0, 8'h00, 8'h93};
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    do_reset();
    run_image(8'd2, t1, 1'b0, -1);

    // Wrong checksum, then bytes offered in the error state must be refused.
    do_reset();
    run_image(8'd2, t1, 1'b1, -1);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (4) begin
      @(negedge clk);
      check("err_holds_ready_low", 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;

    do_reset();
    run_image(8'h21, t1, 1'b0, -1);

    // Full image via length byte 0.
    do_reset();
    pl = {};
    for (int i = 0; i < 4 * WORDS; i++) pl.push_back(8'($urandom_range(0, 255)));
    run_image(8'd0, pl, 1'b0, -1);

    do_reset();
    gaps = 1;
    run_image(8'd2, t1, 1'b0, -1);
    gaps = 0;

    // Abort after six payload bytes, then reload cleanly.
    do_reset();
    run_image(8'd2, t1, 1'b0, 6);
    run_image(8'd2, t1, 1'b0, -1);

    for (int it = 0; it < 6; it++) begin
      do_reset();
      n  = $urandom_range(1, WORDS);
      pl = {};
      for (int i = 0; i < 4 * n; i++) pl.push_back(8'($urandom_range(0, 255)));
      gaps = bit'($urandom_range(0, 1));
      run_image(((n == WORDS) && ($urandom_range(0, 1) == 1)) ? 8'd0 : 8'(n), pl,
                ($urandom_range(0, 3) == 0), -1);
      gaps = 0;
    end

    do_reset();
    run_image(8'($urandom_range(WORDS + 1, 255)), t1, 1'b0, -1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
